// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM encoding, access-size codes and default latency for dmem_responder
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic [1:0] WLEN_B = 2'b00;
    localparam logic [1:0] WLEN_H = 2'b01;
    localparam logic [1:0] WLEN_W = 2'b10;
    localparam logic [1:0] WLEN_D = 2'b11;
    localparam int LATENCY_DEF = 2;
endpackage

// File: rtl/dmem_sram_bank.sv
// dmem_sram_bank: DEPTH x DATA_W storage with per-byte write enables and combinational read
module dmem_sram_bank #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic [DATA_W/8-1:0]        be,
    input  logic [$clog2(DEPTH)-1:0]   idx,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        for (int i = 0; i < DATA_W/8; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];

    assign rdata = mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder for a core load/store port.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned accesses instead of aligning them down.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic              wen_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        wlen_i,
    output logic              ready_o,
    output logic              data_valid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int AB    = IDX_W + OFF_W;

    state_t            state, state_n;
    logic [3:0]        cnt;
    logic              live;
    logic [AB-1:0]     addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        wlen_q;
    logic              accept, commit, mis, w;
    logic [AB-1:0]     a;
    logic [DATA_W-1:0] d, dmask, rd;
    logic [1:0]        l_e;
    logic [OFF_W-1:0]  amask, off;
    logic [NB-1:0]     lanes, be;
    logic              unused_addr;

    assign unused_addr = ^addr_i[ADDR_W-1:AB];

    // live holds ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            live    <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wlen_q  <= '0;
        end else begin
            state <= state_n;
            live  <= 1'b1;
            if (accept) begin
                addr_q  <= addr_i[AB-1:0];
                wen_q   <= wen_i;
                wdata_q <= wdata_i;
                wlen_q  <= wlen_i;
                cnt     <= 4'(LATENCY > 0 ? LATENCY - 1 : 0);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
        end

    // In IDLE the live inputs feed the datapath so a zero-latency store commits on its accept edge
    always_comb begin
        ready_o = live && state == IDLE;
        accept  = req_valid_i && ready_o;
        state_n = state == RESP ? IDLE
                : state == BUSY ? (cnt == '0 ? RESP : BUSY)
                : !accept ? IDLE : (LATENCY == 0 ? RESP : BUSY);
        commit  = state_n == RESP && state != RESP;
        a       = state == IDLE ? addr_i[AB-1:0] : addr_q;
        w       = state == IDLE ? wen_i : wen_q;
        d       = state == IDLE ? wdata_i : wdata_q;
        l_e     = state == IDLE ? wlen_i : wlen_q;
        l_e     = (NB == 4 && l_e == WLEN_D) ? WLEN_W : l_e;
        amask   = l_e == WLEN_B ? '0 : l_e == WLEN_H ? OFF_W'(1) : l_e == WLEN_W ? OFF_W'(3) : OFF_W'(7);
        lanes   = l_e == WLEN_B ? NB'(1) : l_e == WLEN_H ? NB'(3) : l_e == WLEN_W ? NB'(15) : NB'(255);
`ifdef DMEM_MISALIGN_CHECK_EN
        mis     = (a[OFF_W-1:0] & amask) != '0;
`else
        mis     = 1'b0;
`endif
        off     = a[OFF_W-1:0] & ~amask;
        be      = (commit && w && !mis) ? lanes << off : '0;
        data_valid_o = state == RESP;
        rdata_o = (state == RESP && !w && !mis) ? (rd >> {off, 3'b000}) & dmask : '0;
        err_o   = state == RESP && mis;
    end

    for (genvar b = 0; b < NB; b++) begin : g_mask
        assign dmask[8*b +: 8] = {8{lanes[b]}};
    end

    dmem_sram_bank #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_bank (
        .clk   (clk),
        .be    (be),
        .idx   (a[AB-1:OFF_W]),
        .wdata (d << {off, 3'b000}),
        .rdata (rd)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responder configurations checked every cycle against a byte-level model
`timescale 1ns/1ps
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic [1:0]  rst = 2'b11;
    logic [1:0]  req_valid = '0, wen = '0, ready, dv, err;
    logic [31:0] addr [2];
    logic [63:0] wdata [2], rdata [2];
    logic [1:0]  wlen [2];

    always #5 clk = ~clk;

    // instance 0: 32-bit, 1024 words, latency 2; instance 1: 64-bit, 64 words, latency 0
    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int DW = g ? 64 : 32;
        localparam int AW = g ? 16 : 32;
        logic [DW-1:0] rd;
        dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(g ? 64 : 1024), .LATENCY(g ? 0 : 2)) dut (
            .clk(clk), .rst(rst[g]), .req_valid_i(req_valid[g]), .wen_i(wen[g]),
            .addr_i(addr[g][AW-1:0]), .wdata_i(wdata[g][DW-1:0]), .wlen_i(wlen[g]),
            .ready_o(ready[g]), .data_valid_o(dv[g]), .rdata_o(rd), .err_o(err[g]));
        assign rdata[g] = 64'(rd);
    end

    function automatic int lat_of(int s); return s ? 0 : 2; endfunction
    function automatic int nb_of(int s);  return s ? 8 : 4; endfunction
    function automatic int mb_of(int s);  return s ? 512 : 4096; endfunction

    int unsigned cyc = 0;
    int unsigned resp_at [2], free_at [2];
    bit          pend [2], m_ready [2], m_valid [2], m_err [2];
    logic [63:0] m_rdata [2];
    logic        t_w [2];
    logic [31:0] t_a [2];
    logic [63:0] t_d [2];
    logic [1:0]  t_l [2];
    logic [7:0]  mm [2][4096];
    int errors = 0, checks = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset(int s);
        pend[s] = 0; free_at[s] = 0; m_ready[s] = 0; m_valid[s] = 0; m_err[s] = 0; m_rdata[s] = '0;
    endtask

    // Responses land LATENCY+1 cycles after the accept cycle; the port reopens one cycle later
    task automatic model_edge(int s);
        int unsigned sz, ba;
        if (m_ready[s] && req_valid[s]) begin
            t_w[s] = wen[s]; t_a[s] = addr[s]; t_d[s] = wdata[s]; t_l[s] = wlen[s];
            pend[s] = 1; resp_at[s] = cyc + lat_of(s); free_at[s] = resp_at[s] + 1;
        end
        m_valid[s] = 0; m_err[s] = 0; m_rdata[s] = '0;
        if (pend[s] && cyc == resp_at[s]) begin
            pend[s] = 0; m_valid[s] = 1;
            sz = (t_l[s] == 2'd3 && nb_of(s) == 4) ? 4 : 1 << t_l[s];
            ba = t_a[s] % mb_of(s);
`ifdef DMEM_MISALIGN_CHECK_EN
            m_err[s] = (ba % sz) != 0;
`else
            ba = ba - ba % sz;
`endif
            if (!m_err[s])
                for (int i = 0; i < int'(sz); i++)
                    if (t_w[s]) mm[s][ba + i] = t_d[s][8*i +: 8];
                    else m_rdata[s][8*i +: 8] = mm[s][ba + i];
        end
        m_ready[s] = cyc >= free_at[s];
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int s = 0; s < 2; s++) if (rst[s]) model_edge(s);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("ready%0d", s), 64'(ready[s]), 64'(m_ready[s]));
            chk($sformatf("valid%0d", s), 64'(dv[s]), 64'(m_valid[s]));
            chk($sformatf("rdata%0d", s), rdata[s], m_rdata[s]);
            chk($sformatf("err%0d", s), 64'(err[s]), 64'(m_err[s]));
        end
    endtask

    task automatic xact(input int s, input bit w, input logic [31:0] a, input logic [63:0] d,
                        input logic [1:0] l, input bit early,
                        output logic [63:0] r, output logic [63:0] mr, output bit e);
        int n;
        if (!early) tick();
        req_valid[s] = 1'b1; wen[s] = w; addr[s] = a; wdata[s] = d; wlen[s] = l;
        n = 0;
        while (!ready[s] && n < 20) begin tick(); n++; end
        if (!ready[s]) chk($sformatf("accept_timeout%0d", s), 64'(ready[s]), 64'd1);
        tick();
        req_valid[s] = 1'b0; wen[s] = 1'($urandom); addr[s] = $urandom;
        wdata[s] = {$urandom, $urandom}; wlen[s] = 2'($urandom);
        n = 1;
        while (!dv[s] && n < 20) begin tick(); n++; end
        chk($sformatf("latency%0d", s), 64'(n), 64'(lat_of(s) + 1));
        r = rdata[s]; mr = m_rdata[s]; e = err[s];
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] r, mr;
        logic [31:0] ra;
        bit e;
        int seen;
        for (int s = 0; s < 2; s++) begin
            addr[s] = '0; wdata[s] = '0; wlen[s] = '0; model_reset(s);
        end
        rst = 2'b00;
        tick(); tick();
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_valid", 64'(dv), 64'd0);
        rst = 2'b11;
        tick();
        chk("ready_after_release", 64'(ready), 64'd3);

        for (int w = 0; w < 64; w++)
            xact(0, 1, 32'(4*w), (w == 0) ? 64'd0 : 64'(32'hC0DE0000 | 32'(4*w)), 2'd2, 1, r, mr, e);
        for (int w = 0; w < 64; w++)
            xact(1, 1, 32'(8*w), {32'hFACE0000 | 32'(w), 32'hC0DE0000 | 32'(8*w)}, 2'd3, 1, r, mr, e);

        xact(0, 1, 32'h1003, 64'hA5, 2'd0, 0, r, mr, e);
        xact(0, 0, 32'h1000, 64'd0, 2'd2, 0, r, mr, e);
        chk("byte_store_word_load", r, 64'hA500_0000);
        chk("model_byte_store", mr, 64'hA500_0000);
        xact(0, 1, 32'h20, 64'h1122_3344, 2'd2, 0, r, mr, e);
        xact(0, 0, 32'h22, 64'd0, 2'd1, 0, r, mr, e);
        chk("half_load", r, 64'h1122);
        chk("model_half_load", mr, 64'h1122);
        xact(0, 1, 32'h1000, 64'hDEAD_BEEF, 2'd2, 0, r, mr, e);
        xact(0, 0, 32'h0, 64'd0, 2'd2, 0, r, mr, e);
        chk("wrap_load", r, 64'hDEAD_BEEF);
        xact(0, 1, 32'h41, 64'hFFFF_FFFF, 2'd2, 0, r, mr, e);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("misaligned_err", 64'(e), 64'd1);
        xact(0, 0, 32'h40, 64'd0, 2'd2, 0, r, mr, e);
        chk("misaligned_store_suppressed", r, 64'hC0DE_0040);
`else
        chk("aligned_down_err", 64'(e), 64'd0);
        xact(0, 0, 32'h40, 64'd0, 2'd2, 0, r, mr, e);
        chk("aligned_down_store", r, 64'hFFFF_FFFF);
`endif

        tick();
        req_valid[0] = 1'b1; wen[0] = 1'b1; addr[0] = 32'h80; wdata[0] = 64'h1234_5678; wlen[0] = 2'd2;
        chk("reset_test_ready", 64'(ready[0]), 64'd1);
        tick();
        req_valid[0] = 1'b0;
        chk("busy_not_ready", 64'(ready[0]), 64'd0);
        rst[0] = 1'b0; model_reset(0);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ready_in_reset", 64'(ready[0]), 64'd0);
            seen += int'(dv[0]);
        end
        rst[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin tick(); seen += int'(dv[0]); end
        chk("no_resp_after_abort", 64'(seen), 64'd0);
        xact(0, 0, 32'h80, 64'd0, 2'd2, 0, r, mr, e);
        chk("abort_no_commit", r, 64'hC0DE_0080);

        xact(1, 1, 32'h08, 64'h0123_4567_89AB_CDEF, 2'd3, 0, r, mr, e);
        xact(1, 0, 32'h0C, 64'd0, 2'd1, 0, r, mr, e);
        chk("dword_half_load", r, 64'h4567);
        xact(1, 0, 32'h0C, 64'd0, 2'd2, 0, r, mr, e);
        chk("dword_word_load", r, 64'h0123_4567);
        xact(1, 0, 32'h208, 64'd0, 2'd3, 0, r, mr, e);
        chk("dword_wrap_load", r, 64'h0123_4567_89AB_CDEF);

        tick();
        req_valid[1] = 1'b1; wen[1] = 1'b0; addr[1] = 32'h08; wlen[1] = 2'd3;
        for (int k = 0; k < 6; k++) begin
            chk("b2b_ready", 64'(ready[1]), 64'(k % 2 == 0));
            chk("b2b_valid", 64'(dv[1]), 64'(k % 2 == 1));
            if (k % 2 == 1) chk("b2b_rdata", rdata[1], 64'h0123_4567_89AB_CDEF);
            tick();
        end
        req_valid[1] = 1'b0;

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 250; i++) begin
                ra = $urandom;
                xact(s, 1'($urandom), (s == 0) ? {ra[31:12], 4'h0, ra[7:0]} : ra,
                     {$urandom, $urandom}, 2'($urandom), $urandom_range(0, 2) == 0, r, mr, e);
                repeat ($urandom_range(0, 2)) tick();
            end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning request address width (equals core address bus).
REQ-002 SHALL have parameter DATA_W, default 32, meaning data word width; the only legal values are 32 and 64.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning number of DATA_W words stored; it is a power of two.
REQ-004 SHALL have parameter LATENCY, default 2, meaning wait cycles between accept and response; the legal range is 0..15.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1, meaning the reset: asynchronous, active-low.
REQ-007 SHALL have port req_valid_i, input, 1, meaning the core presents a request.
REQ-008 SHALL have port wen_i, input, 1, meaning 1=store, 0=load.
REQ-009 SHALL have port addr_i, input, ADDR_W, meaning the byte address.
REQ-010 SHALL have port wdata_i, input, DATA_W, meaning store data, LSB-aligned.
REQ-011 SHALL have port wlen_i, input, 2, meaning access size: 00 byte, 01 half, 10 word, 11 dword.
REQ-012 SHALL have port ready_o, output, 1, meaning the responder can accept a request this cycle.
REQ-013 SHALL have port data_valid_o, output, 1, meaning a one-cycle response strobe.
REQ-014 SHALL have port rdata_o, output, DATA_W, meaning load data right-shifted to the LSBs.
REQ-015 SHALL have port err_o, output, 1, meaning the response is for a misaligned access.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-017 SHALL assert ready_o only in IDLE.
REQ-018 SHALL treat a request as accepted only on a cycle where req_valid_i=1 and ready_o=1.
REQ-019 SHALL register addr, wen, wdata and wlen at accept; later input changes are ignored until the next accept.
REQ-020 SHALL go IDLE->BUSY at accept when LATENCY>0, with the wait counter loaded to LATENCY-1; when LATENCY=0 it SHALL go IDLE->RESP directly.
REQ-021 SHALL go BUSY->RESP when the counter reaches 0, decrementing once per cycle before that.
REQ-022 SHALL always go RESP->IDLE after one cycle; back-to-back requests therefore occur at most every LATENCY+2 cycles.
REQ-023 SHALL assert data_valid_o for exactly the RESP cycle, for both loads and stores; the store acknowledgment is data_valid_o with rdata_o=0.
REQ-024 SHALL form the word index from addr bits [log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)]; upper bits are ignored, so addresses wrap modulo the memory size.
REQ-025 SHALL, for a load, return the selected word shifted right by 8*byte_offset, with bits above the access size zeroed; sign extension belongs to the core.
REQ-026 SHALL, for a store, write only the byte lanes covered by wlen at the byte offset, on the clock edge entering RESP.
REQ-027 SHALL, when DATA_W=32, treat wlen=11 as wlen=10.
REQ-028 SHALL drive rdata_o and err_o as 0 outside RESP.

Reset
REQ-029 SHALL, while rst=0, hold the FSM in IDLE, clear the counter and the captured registers, and drive ready_o=0, data_valid_o=0, rdata_o=0, err_o=0.
REQ-030 SHALL, on reset asserted in BUSY, abort the transaction: no store is committed and no response is issued.
REQ-031 SHALL NOT clear memory contents on reset.
REQ-032 SHALL raise ready_o on the first clock edge after rst deasserts.

Configuration
REQ-033 SHALL, when DMEM_MISALIGN_CHECK_EN is defined, flag misalignment (half at an odd address, word with addr[1:0]!=0, dword with addr[2:0]!=0); a misaligned access still completes the normal LATENCY timing, suppresses the store, returns rdata_o=0, and sets err_o=1 in RESP.
REQ-034 SHALL, when DMEM_MISALIGN_CHECK_EN is undefined, align the address down to the access size, perform the access normally, and tie err_o to 0.

Structure
REQ-035 SHALL place the FSM state encoding, the wlen encodings (WLEN_B/H/W/D) and the LATENCY default in shared package dmem_pkg.
REQ-036 SHALL instantiate one sub-module, dmem_sram_bank: a synchronous DEPTH x DATA_W array with per-byte write enables and a combinational read of the registered index.

Verification
REQ-037 SHALL cover a byte store and word load (DATA_W=32, LATENCY=2): store 0xA5 to 0x1003, then load a word from 0x1000; data_valid_o is high 3 cycles after each accept and rdata_o=0xA5000000 with the other lanes unchanged.
REQ-038 SHALL cover a half load: preload 0x11223344 at 0x20, load a half from 0x22; rdata_o=0x00001122.
REQ-039 SHALL cover wrap-around (DEPTH=1024): store a word 0xDEADBEEF at 0x1000, load from 0x0; rdata_o=0xDEADBEEF.
REQ-040 SHALL cover a misaligned store with DMEM_MISALIGN_CHECK_EN defined: word store 0xFFFFFFFF at 0x41; err_o=1 in RESP and a subsequent word load at 0x40 returns its old contents.
REQ-041 SHALL cover reset mid-operation: store 0x12345678 to 0x80, pull rst low in BUSY; no data_valid_o occurs, ready_o=0 during reset, and 0x80 is unchanged after release.
REQ-042 SHALL cover LATENCY=0 back-to-back requests: ready_o is low in RESP, and a held request is accepted in the following IDLE cycle at a 2-cycle cadence.
